// File: rtl/rd_bus_arbiter.sv
// rd_bus_arbiter: shares one tiny-AXI read channel between the I-cache and
// D-cache miss engines. Start pulses are latched per side, one winner is
// granted (round-robin or fixed I-priority on a tie), a single bus read is
// issued, and the data-valid / finish pulses are routed back to the owner.
// A watchdog aborts a hung read; a per-side flush squashes that side's pulses.
module rd_bus_arbiter #(
    parameter bit RR_EN     = 1'b1,
    parameter int TO_CYCLES = 256,
    parameter int TO_W      = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_start_rq,
    input  logic [31:0] ic_addr,
    input  logic        ic_flush,
    output logic        ic_rdat_valid,
    output logic        ic_finish,
    input  logic        dc_start_rq,
    input  logic [31:0] dc_addr,
    input  logic        dc_flush,
    output logic        dc_rdat_valid,
    output logic        dc_finish,
    output logic        rd_start_rq,
    output logic [31:0] rd_in_addr,
    input  logic        rdat_m_valid,
    input  logic        finish_mrd,
    output logic        gnt_ic,
    output logic        busy,
    input  logic        clr_err,
    output logic        req_err,
    output logic        to_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        WAIT_FIN  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    state_t          state;
    logic            ic_pend;
    logic            dc_pend;
    logic [31:0]     ic_addr_q;
    logic [31:0]     dc_addr_q;
    logic            last_gnt_ic;
    logic            ic_squash;
    logic            dc_squash;
    logic [TO_W-1:0] wd_cnt;

    logic data_beat;
    logic bus_done;
    logic in_wait;
    logic timeout;
    logic ic_outst;
    logic dc_outst;
    logic ic_accept;
    logic dc_accept;
    logic req_drop;
    logic ic_cand;
    logic dc_cand;
    logic grant;
    logic win_ic;

    // Bus handshake decode: a data beat only counts while waiting for data,
    // and the read completes on finish after (or together with) that beat.
    assign busy      = (state != IDLE);
    assign in_wait   = (state == WAIT_DATA) || (state == WAIT_FIN);
    assign data_beat = (state == WAIT_DATA) && rdat_m_valid;
    assign bus_done  = finish_mrd && ((state == WAIT_FIN) || data_beat);
    assign timeout   = in_wait && (wd_cnt == TO_LAST) && !bus_done;

    // Routed pulses are combinational so the requester sees them in the bus cycle.
    assign ic_rdat_valid = data_beat &&  gnt_ic && !ic_squash;
    assign dc_rdat_valid = data_beat && !gnt_ic && !dc_squash;
    assign ic_finish     = bus_done  &&  gnt_ic && !ic_squash;
    assign dc_finish     = bus_done  && !gnt_ic && !dc_squash;

    // A side is outstanding while pending or owning an unfinished read; a
    // request in the cycle of its own finish is therefore accepted.
    assign ic_outst  = ic_pend || (busy &&  gnt_ic && !ic_finish);
    assign dc_outst  = dc_pend || (busy && !gnt_ic && !dc_finish);
    assign ic_accept = ic_start_rq && !ic_flush && !ic_outst;
    assign dc_accept = dc_start_rq && !dc_flush && !dc_outst;
    assign req_drop  = (ic_start_rq && !ic_flush && ic_outst) ||
                       (dc_start_rq && !dc_flush && dc_outst);

    // Arbitration: a flush in the same cycle withdraws that side's pending request.
    assign ic_cand = ic_pend && !ic_flush;
    assign dc_cand = dc_pend && !dc_flush;
    assign grant   = (state == IDLE) && (ic_cand || dc_cand);
    assign win_ic  = ic_cand && (!dc_cand || !RR_EN || !last_gnt_ic);

    // Per-side pending latch: flush beats a new request, grant consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_pend   <= 1'b0;
            dc_pend   <= 1'b0;
            ic_addr_q <= '0;
            dc_addr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, so the priority order below is order-independent.
            if (ic_flush) begin
                ic_pend <= 1'b0;
            end else if (ic_accept) begin
                ic_pend   <= 1'b1;
                ic_addr_q <= ic_addr;
            end else if (grant && win_ic) begin
                ic_pend <= 1'b0;
            end

            if (dc_flush) begin
                dc_pend <= 1'b0;
            end else if (dc_accept) begin
                dc_pend   <= 1'b1;
                dc_addr_q <= dc_addr;
            end else if (grant && !win_ic) begin
                dc_pend <= 1'b0;
            end
        end
    end

    // Transaction FSM with registered start pulse, address, owner, watchdog and squash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_start_rq <= 1'b0;
            rd_in_addr  <= '0;
            gnt_ic      <= 1'b0;
            last_gnt_ic <= 1'b0;
            wd_cnt      <= '0;
            ic_squash   <= 1'b0;
            dc_squash   <= 1'b0;
        end else begin
            // NOTE: default-low here makes rd_start_rq a one-cycle pulse without
            // having to clear it explicitly in every state.
            rd_start_rq <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt    <= '0;
                    ic_squash <= 1'b0;
                    dc_squash <= 1'b0;
                    if (grant) begin
                        state       <= ISSUE;
                        rd_start_rq <= 1'b1;
                        gnt_ic      <= win_ic;
                        last_gnt_ic <= win_ic;
                        rd_in_addr  <= win_ic ? ic_addr_q : dc_addr_q;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT_DATA;
                end
                WAIT_DATA, WAIT_FIN: begin
                    wd_cnt <= wd_cnt + TO_W'(1);
                    if (bus_done || timeout) begin
                        state <= IDLE;
                    end else if (data_beat) begin
                        state <= WAIT_FIN;
                    end
                end
                default: state <= IDLE;
            endcase

            // Flushing the owner squashes its remaining pulses; IDLE clears it.
            if (busy) begin
                if (ic_flush && gnt_ic) begin
                    ic_squash <= 1'b1;
                end
                if (dc_flush && !gnt_ic) begin
                    dc_squash <= 1'b1;
                end
            end
        end
    end

    // Sticky error flags: a set event in the same cycle wins over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_err <= 1'b0;
            to_err  <= 1'b0;
        end else begin
            if (req_drop) begin
                req_err <= 1'b1;
            end else if (clr_err) begin
                req_err <= 1'b0;
            end

            if (timeout) begin
                to_err <= 1'b1;
            end else if (clr_err) begin
                to_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rd_bus_arbiter.sv
// Testbench for rd_bus_arbiter: two instances (round-robin and fixed
// I-priority) share directed stimulus and a simple bus responder. A
// transaction-level model predicts every output each cycle; literal checks
// pin the model against hand-computed timings.
module tb_rd_bus_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_start_rq;
    logic [31:0] ic_addr;
    logic        ic_flush;
    logic        dc_start_rq;
    logic [31:0] dc_addr;
    logic        dc_flush;
    logic        rdat_m_valid;
    logic        finish_mrd;
    logic        clr_err;

    logic        ic_rdat_valid [2];
    logic        ic_finish     [2];
    logic        dc_rdat_valid [2];
    logic        dc_finish     [2];
    logic        rd_start_rq   [2];
    logic [31:0] rd_in_addr    [2];
    logic        gnt_ic        [2];
    logic        busy          [2];
    logic        req_err       [2];
    logic        to_err        [2];

    int checks = 0;
    int errors = 0;

    // Bus responder knobs: cycles after the start pulse for data and finish.
    int since = -1;
    int dly_v = 1;
    int dly_f = 3;

    always #5 clk = ~clk;

    rd_bus_arbiter #(.RR_EN(1'b1), .TO_CYCLES(TO), .TO_W(5)) u_rr (
        .clk(clk), .rst(rst),
        .ic_start_rq(ic_start_rq), .ic_addr(ic_addr), .ic_flush(ic_flush),
        .ic_rdat_valid(ic_rdat_valid[0]), .ic_finish(ic_finish[0]),
        .dc_start_rq(dc_start_rq), .dc_addr(dc_addr), .dc_flush(dc_flush),
        .dc_rdat_valid(dc_rdat_valid[0]), .dc_finish(dc_finish[0]),
        .rd_start_rq(rd_start_rq[0]), .rd_in_addr(rd_in_addr[0]),
        .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
        .gnt_ic(gnt_ic[0]), .busy(busy[0]), .clr_err(clr_err),
        .req_err(req_err[0]), .to_err(to_err[0])
    );

    rd_bus_arbiter #(.RR_EN(1'b0), .TO_CYCLES(TO), .TO_W(5)) u_fix (
        .clk(clk), .rst(rst),
        .ic_start_rq(ic_start_rq), .ic_addr(ic_addr), .ic_flush(ic_flush),
        .ic_rdat_valid(ic_rdat_valid[1]), .ic_finish(ic_finish[1]),
        .dc_start_rq(dc_start_rq), .dc_addr(dc_addr), .dc_flush(dc_flush),
        .dc_rdat_valid(dc_rdat_valid[1]), .dc_finish(dc_finish[1]),
        .rd_start_rq(rd_start_rq[1]), .rd_in_addr(rd_in_addr[1]),
        .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
        .gnt_ic(gnt_ic[1]), .busy(busy[1]), .clr_err(clr_err),
        .req_err(req_err[1]), .to_err(to_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model. Side index 0 = IC, 1 = DC. age counts cycles since
    // the grant (0 = start-pulse cycle); got marks the data beat seen.
    typedef struct {
        bit [1:0]       pend;
        bit [1:0][31:0] aq;
        bit             act;
        bit             own;
        int             age;
        bit             got;
        bit [1:0]       sq;
        bit             last;
        bit [31:0]      addr;
        bit             rerr;
        bit             terr;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.pend = '0; s.aq = '0; s.act = 1'b0; s.own = 1'b1; s.age = 0;
        s.got = 1'b0; s.sq = '0; s.last = 1'b1; s.addr = '0;
        s.rerr = 1'b0; s.terr = 1'b0;
        return s;
    endfunction

    // Flags order: {rd_start, gnt_ic, busy, ic_v, ic_f, dc_v, dc_f, req_err, to_err}
    function automatic void mdl_step(input mdl_t s, input bit rr, output logic [8:0] ef,
                                     output logic [31:0] ea, output mdl_t n);
        bit [1:0]       st, fl, v, f, outst, cand;
        bit [1:0][31:0] ad;
        bit             beat, ending, tmo, drop, wb;
        st = {dc_start_rq, ic_start_rq};
        fl = {dc_flush, ic_flush};
        ad = {dc_addr, ic_addr};
        beat   = s.act && s.age >= 1 && !s.got && rdat_m_valid;
        ending = s.act && s.age >= 1 && finish_mrd && (s.got || rdat_m_valid);
        tmo    = s.act && s.age == TO && !ending;
        for (int x = 0; x < 2; x++) begin
            v[x]     = beat   && s.own == 1'(x) && !s.sq[x];
            f[x]     = ending && s.own == 1'(x) && !s.sq[x];
            outst[x] = s.pend[x] || (s.act && s.own == 1'(x) && !f[x]);
        end
        ef = {s.act && s.age == 0, !s.own, s.act, v[0], f[0], v[1], f[1], s.rerr, s.terr};
        ea = s.addr;
        drop = |(st & ~fl & outst);
        n = s;
        for (int x = 0; x < 2; x++) begin
            if (fl[x]) n.pend[x] = 1'b0;
            else if (st[x] && !outst[x]) begin
                n.pend[x] = 1'b1;
                n.aq[x]   = ad[x];
            end
        end
        n.rerr = drop ? 1'b1 : (clr_err ? 1'b0 : s.rerr);
        n.terr = tmo  ? 1'b1 : (clr_err ? 1'b0 : s.terr);
        if (!s.act) begin
            cand = s.pend & ~fl;
            if (cand != 2'b00) begin
                wb = (cand == 2'b11) ? (rr ? !s.last : 1'b0) : cand[1];
                n.act = 1'b1; n.age = 0; n.got = 1'b0; n.sq = '0;
                n.own = wb; n.last = wb; n.addr = s.aq[wb];
                n.pend[wb] = 1'b0;
            end
        end else if (ending || tmo) begin
            n.act = 1'b0;
            n.sq  = '0;
        end else begin
            n.age = s.age + 1;
            if (beat) n.got = 1'b1;
            for (int x = 0; x < 2; x++)
                if (fl[x] && s.own == 1'(x)) n.sq[x] = 1'b1;
        end
    endfunction

    mdl_t m [2];

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        mdl_t        nx;
        logic [8:0]  ef;
        logic [31:0] ea;
        logic [8:0]  af;
        for (int d = 0; d < 2; d++) begin
            if (rst) m[d] = mdl_reset();
            mdl_step(m[d], d == 0, ef, ea, nx);
            af = {rd_start_rq[d], gnt_ic[d], busy[d], ic_rdat_valid[d], ic_finish[d],
                  dc_rdat_valid[d], dc_finish[d], req_err[d], to_err[d]};
            check($sformatf("dut%0d flags @%0t", d, $time), 32'(af), 32'(ef));
            check($sformatf("dut%0d addr @%0t", d, $time), rd_in_addr[d], ea);
            m[d] = rst ? mdl_reset() : nx;
        end
    end

    // One clock: clear pulses, then drive the bus responder for this cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        ic_start_rq = 1'b0; dc_start_rq = 1'b0;
        ic_flush = 1'b0; dc_flush = 1'b0; clr_err = 1'b0;
        if (rd_start_rq[0]) since = 0;
        else if (!busy[0]) since = -1;
        else if (since >= 0) since++;
        rdat_m_valid = (since >= 1) && (since == dly_v);
        finish_mrd   = (since >= 1) && (since == dly_f);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ic_start_rq = 1'b0; ic_addr = '0; ic_flush = 1'b0;
        dc_start_rq = 1'b0; dc_addr = '0; dc_flush = 1'b0;
        rdat_m_valid = 1'b0; finish_mrd = 1'b0; clr_err = 1'b0;
        wait_cyc(2);
        @(negedge clk);
        check("reset busy", 32'(busy[0]), 32'd0);
        check("reset addr", rd_in_addr[0], 32'd0);
        check("reset gnt", 32'(gnt_ic[0]), 32'd0);
        cyc(); rst = 1'b0;
        wait_cyc(2);

        // Single IC read: start at t+2, data t+3, finish t+5.
        dly_v = 1; dly_f = 3;
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'h0000_1230;
        wait_cyc(2);
        @(negedge clk);
        check("t1 start", 32'(rd_start_rq[0]), 32'd1);
        check("t1 addr", rd_in_addr[0], 32'h0000_1230);
        check("t1 gnt", 32'(gnt_ic[0]), 32'd1);
        cyc();
        @(negedge clk);
        check("t1 valid", 32'(ic_rdat_valid[0]), 32'd1);
        check("t1 dc quiet", 32'({dc_rdat_valid[0], dc_finish[0]}), 32'd0);
        wait_cyc(2);
        ic_start_rq = 1'b1; ic_addr = 32'h0000_4560;   // request in own finish cycle
        @(negedge clk);
        check("t1 finish", 32'(ic_finish[0]), 32'd1);
        wait_cyc(2);
        @(negedge clk);
        check("t1 reissue addr", rd_in_addr[0], 32'h0000_4560);
        check("t1 no req_err", 32'(req_err[0]), 32'd0);
        wait_cyc(5);

        // Reset in the middle of a transaction.
        dly_v = 2; dly_f = 3;
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'hAAAA_0000;
        wait_cyc(3);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst busy", 32'(busy[0]), 32'd0);
        check("mid rst addr", rd_in_addr[0], 32'd0);
        cyc(); rst = 1'b0;
        wait_cyc(4);

        // Tie #1 right after reset: both instances grant IC first, then DC.
        dly_v = 1; dly_f = 1;
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'h100; dc_start_rq = 1'b1; dc_addr = 32'h200;
        wait_cyc(2);
        @(negedge clk);
        check("tie1 rr first", 32'(gnt_ic[0]), 32'd1);
        check("tie1 fix first", 32'(gnt_ic[1]), 32'd1);
        wait_cyc(3);
        @(negedge clk);
        check("tie1 rr second", 32'(gnt_ic[0]), 32'd0);
        check("tie1 second addr", rd_in_addr[0], 32'h200);
        check("tie1 fix second", 32'(gnt_ic[1]), 32'd0);
        wait_cyc(3);
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'h300;   // last grant becomes IC
        wait_cyc(6);
        // Tie #2: round-robin now prefers DC, fixed priority still IC.
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'h400; dc_start_rq = 1'b1; dc_addr = 32'h500;
        wait_cyc(2);
        @(negedge clk);
        check("tie2 rr first", 32'(gnt_ic[0]), 32'd0);
        check("tie2 rr addr", rd_in_addr[0], 32'h500);
        check("tie2 fix first", 32'(gnt_ic[1]), 32'd1);
        wait_cyc(3);
        @(negedge clk);
        check("tie2 rr second", 32'(gnt_ic[0]), 32'd1);
        check("tie2 fix second", 32'(gnt_ic[1]), 32'd0);
        wait_cyc(4);

        // DC request while IC in flight: issued after IC finish + one IDLE cycle.
        dly_v = 1; dly_f = 3;
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'h600;
        wait_cyc(3);
        dc_start_rq = 1'b1; dc_addr = 32'h700;
        wait_cyc(3);
        @(negedge clk);
        check("dc wait idle", 32'(busy[0]), 32'd0);
        cyc();
        @(negedge clk);
        check("dc issue", 32'({rd_start_rq[0], gnt_ic[0]}), 32'b10);
        check("dc issue addr", rd_in_addr[0], 32'h700);
        check("dc no req_err", 32'(req_err[0]), 32'd0);
        wait_cyc(5);

        // IC flush during WAIT_DATA: bus completes, IC pulses suppressed.
        dly_v = 3; dly_f = 4;
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'h800;
        wait_cyc(3);
        ic_flush = 1'b1;
        wait_cyc(2);
        @(negedge clk);
        check("flush valid squashed", 32'(ic_rdat_valid[0]), 32'd0);
        cyc();
        @(negedge clk);
        check("flush finish squashed", 32'(ic_finish[0]), 32'd0);
        check("flush still busy", 32'(busy[0]), 32'd1);
        cyc();
        @(negedge clk);
        check("flush done", 32'(busy[0]), 32'd0);
        dly_v = 1; dly_f = 3;
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'h900;
        wait_cyc(3);
        @(negedge clk);
        check("post flush valid", 32'(ic_rdat_valid[0]), 32'd1);
        wait_cyc(4);

        // Dropped duplicate request sets req_err; clr_err clears it.
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'hA00;
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'hB00;
        cyc();
        @(negedge clk);
        check("drop req_err", 32'(req_err[0]), 32'd1);
        check("drop keeps addr", rd_in_addr[0], 32'hA00);
        wait_cyc(4);
        clr_err = 1'b1;
        cyc();
        @(negedge clk);
        check("clr req_err", 32'(req_err[0]), 32'd0);
        wait_cyc(2);

        // Watchdog: no data for 16 wait cycles, then pending DC issues.
        dly_v = 1000; dly_f = 1000;
        cyc(); ic_start_rq = 1'b1; ic_addr = 32'hC00;
        wait_cyc(4);
        dc_start_rq = 1'b1; dc_addr = 32'hD00;
        wait_cyc(14);
        @(negedge clk);
        check("wd last wait busy", 32'(busy[0]), 32'd1);
        check("wd no err yet", 32'(to_err[0]), 32'd0);
        cyc();
        dly_v = 1; dly_f = 2;
        @(negedge clk);
        check("wd abort busy", 32'(busy[0]), 32'd0);
        check("wd to_err", 32'({to_err[0], to_err[1]}), 32'b11);
        cyc();
        @(negedge clk);
        check("wd dc issue", 32'({rd_start_rq[0], gnt_ic[0]}), 32'b10);
        check("wd dc addr", rd_in_addr[0], 32'hD00);
        wait_cyc(5);
        clr_err = 1'b1;
        cyc();
        @(negedge clk);
        check("clr to_err", 32'(to_err[0]), 32'd0);
        wait_cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
